dac_wave_gen: RTL and testbench

Sample source that sits directly upstream of the serial DAC controller. It generates a sawtooth, or optionally a triangle, waveform at a programmable sample rate. Each DW-bit sample is handed to the serializer over a valid/ready handshake, and one sample is produced every DIV clock cycles while enabled. The serializer asserts READY when it is idle and can start a new SCK/Dout/CSLD frame.

---
 rtl/dac_wave_gen.sv | 102 ++++++++++
 tb/tb_dac_wave_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dac_wave_gen.sv
// Sawtooth/triangle sample source for the serial DAC. Triangle mode requires DAC_WAVE_TRIANGLE_EN.
// One sample every DIV cycles; DATA/VALID are registered and appear after the tick edge.
// VALID/READY handshake. A tick that overwrites an unaccepted sample sets sticky OVR.
module dac_wave_gen #(
   parameter int DW  = 12,
   parameter int DIV = 25
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          EN,
   input  logic [DW-1:0] STEP,
   input  logic          MODE,
   output logic [DW-1:0] DATA,
   output logic          VALID,
   input  logic          READY,
   output logic          OVR
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

   logic [CW-1:0] cnt;
   logic [DW-1:0] acc;
   logic [DW-1:0] acc_nxt;
   logic          tick;

   assign tick = EN && (cnt == CNT_MAX);

`ifdef DAC_WAVE_TRIANGLE_EN
   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;
   localparam logic [DW-1:0] MAXV = '1;

   dir_t dir;
   dir_t dir_nxt;

   // Triangle clamps at the rails instead of wrapping, then reverses.
   always_comb begin
      acc_nxt = acc + STEP;
      dir_nxt = dir;
      if (MODE) begin
         if (dir == DIR_UP) begin
            if (acc > MAXV - STEP) begin
               acc_nxt = MAXV;
               dir_nxt = DIR_DOWN;
            end
         end else begin
            if (acc < STEP) begin
               acc_nxt = '0;
               dir_nxt = DIR_UP;
            end else begin
               acc_nxt = acc - STEP;
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         dir <= DIR_UP;
      end else if (tick) begin
         dir <= dir_nxt;
      end
   end
`else
   logic unused_mode;
   assign unused_mode = MODE;

   always_comb begin
      acc_nxt = acc + STEP;
   end
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt <= '0;
      end else if (!EN || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // The sample emitted is the pre-update accumulator, so the first sample is 0.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         acc   <= '0;
         DATA  <= '0;
         VALID <= 1'b0;
         OVR   <= 1'b0;
      end else if (tick) begin
         acc   <= acc_nxt;
         DATA  <= acc;
         VALID <= 1'b1;
         if (VALID && !READY) begin
            OVR <= 1'b1;
         end
      end else if (VALID && READY) begin
         VALID <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dac_wave_gen.sv
// Directed bench for dac_wave_gen with DIV=4, DW=12; expectations follow DAC_WAVE_TRIANGLE_EN.
module tb_dac_wave_gen;

   logic        clk;
   logic        rst;
   logic        en;
   logic [11:0] step;
   logic        mode;
   logic [11:0] data;
   logic        valid;
   logic        ready;
   logic        ovr;

   int n_cmp;
   int n_err;
   logic [11:0] seq [8];

   dac_wave_gen #(.DW(12), .DIV(4)) dut (
      .CLK   (clk),
      .RST   (rst),
      .EN    (en),
      .STEP  (step),
      .MODE  (mode),
      .DATA  (data),
      .VALID (valid),
      .READY (ready),
      .OVR   (ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Holds reset for one edge; caller programs inputs and raises EN before the next edge.
   task automatic do_reset();
      rst   = 1'b1;
      en    = 1'b0;
      ready = 1'b1;
      step  = '0;
      mode  = 1'b0;
      cyc(1);
      rst   = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      en    = 1'b0;
      ready = 1'b1;
      step  = '0;
      mode  = 1'b0;

      // Reset state
      cyc(2);
      chk("rst_data", data, 0);
      chk("rst_valid", valid, 0);
      chk("rst_ovr", ovr, 0);

      // Basic sawtooth, first tick on edge 4, 1-cycle VALID pulses
      rst = 1'b0; step = 12'd16; en = 1'b1;
      cyc(3);
      chk("basic_pre_tick_valid", valid, 0);
      cyc(1);
      chk("basic_s0_valid", valid, 1);
      chk("basic_s0_data", data, 0);
      cyc(1);
      chk("basic_pulse_end", valid, 0);
      cyc(3);
      chk("basic_s1_data", data, 16);
      chk("basic_s1_valid", valid, 1);
      cyc(4);
      chk("basic_s2_data", data, 32);
      cyc(4);
      chk("basic_s3_data", data, 48);
      chk("basic_ovr", ovr, 0);

      // Natural wrap in sawtooth
      do_reset();
      step = 12'h400; en = 1'b1;
      seq[0] = 12'h000; seq[1] = 12'h400; seq[2] = 12'h800; seq[3] = 12'hC00; seq[4] = 12'h000;
      for (int i = 0; i < 5; i++) begin
         cyc(4);
         chk($sformatf("wrap_s%0d", i), data, seq[i]);
      end

      // Triangle (or sawtooth fallback when triangle logic is compiled out)
      do_reset();
      step = 12'h600; mode = 1'b1; en = 1'b1;
`ifdef DAC_WAVE_TRIANGLE_EN
      seq[0] = 12'h000; seq[1] = 12'h600; seq[2] = 12'hC00; seq[3] = 12'hFFF;
      seq[4] = 12'h9FF; seq[5] = 12'h3FF; seq[6] = 12'h000; seq[7] = 12'h600;
`else
      seq[0] = 12'h000; seq[1] = 12'h600; seq[2] = 12'hC00; seq[3] = 12'h200;
      seq[4] = 12'h800; seq[5] = 12'hE00; seq[6] = 12'h400; seq[7] = 12'hA00;
`endif
      for (int i = 0; i < 8; i++) begin
         cyc(4);
         chk($sformatf("tri_s%0d", i), data, seq[i]);
      end

      // Overrun: two ticks without READY
      do_reset();
      step = 12'd16; ready = 1'b0; en = 1'b1;
      cyc(4);
      chk("ovr_t1_valid", valid, 1);
      chk("ovr_t1_ovr", ovr, 0);
      cyc(4);
      chk("ovr_t2_data", data, 16);
      chk("ovr_t2_valid", valid, 1);
      chk("ovr_t2_ovr", ovr, 1);
      ready = 1'b1;
      cyc(1);
      chk("ovr_accept_valid", valid, 0);
      chk("ovr_sticky", ovr, 1);

      // READY rises exactly on a tick edge
      do_reset();
      step = 12'd16; ready = 1'b0; en = 1'b1;
      cyc(4);
      chk("sim_pend_data", data, 0);
      cyc(3);
      chk("sim_pend_valid", valid, 1);
      ready = 1'b1;
      cyc(1);
      chk("sim_valid", valid, 1);
      chk("sim_data", data, 16);
      chk("sim_ovr", ovr, 0);
      cyc(1);
      chk("sim_accept", valid, 0);

      // EN low mid-run retains acc; next tick DIV edges after re-enable
      do_reset();
      step = 12'd16; en = 1'b1;
      cyc(8);
      chk("en_s1_data", data, 16);
      cyc(2);
      en = 1'b0;
      cyc(10);
      chk("en_off_valid", valid, 0);
      chk("en_off_data", data, 16);
      en = 1'b1;
      cyc(3);
      chk("en_re_pre_valid", valid, 0);
      cyc(1);
      chk("en_re_valid", valid, 1);
      chk("en_re_data", data, 32);

      // Asynchronous reset during a pending, overrun sample
      do_reset();
      step = 12'd16; ready = 1'b0; en = 1'b1;
      cyc(8);
      chk("mrst_pre_ovr", ovr, 1);
      chk("mrst_pre_data", data, 16);
      rst = 1'b1;
      #1;
      chk("mrst_data", data, 0);
      chk("mrst_valid", valid, 0);
      chk("mrst_ovr", ovr, 0);
      cyc(1);
      rst = 1'b0; ready = 1'b1;
      cyc(4);
      chk("mrst_next_valid", valid, 1);
      chk("mrst_next_data", data, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
